negedge_deser: RTL and testbench
================================

Name: negedge_deser

Overview:
- Posedge-clocked serial-to-parallel collector. It sits directly downstream of a negedge-launched flop stage (TECH_FF-style cells).
- Samples the bit stream those flops produce, assembles WIDTH-bit words, and presents each word on a valid/ready output.
- The path from the negedge launch to the posedge capture is a half-cycle path. Timing closure is handled outside this block.

Parameters:
- WIDTH, 8, bits per assembled word (range 2..32).
- MSB_FIRST, 1, 1: first received bit lands in word_out[WIDTH-1]; 0: first bit lands in word_out[0].

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- bit_in  input  1  serial data from the upstream negedge flop.
- bit_vld  input  1  bit_in is meaningful this cycle.
- word_out  output  WIDTH  assembled word (registered).
- word_vld  output  1  word_out holds an unconsumed word.
- word_rdy  input  1  downstream accepts word_out when word_vld is high.
- overflow  output  1  sticky: at least one bit was dropped.
- parity_err  output  1  parity flag qualified by word_vld; tied 0 unless PARITY_CHECK_EN is defined.

Behaviour:
- Reset: state=COLLECT, bit counter cnt=0, shift register sr=0, word_out=0, word_vld=0, overflow=0, parity_err=0. Reset mid-word discards the partial word and any held word.
- Output slot is free in a cycle when (!word_vld || word_rdy).
- FSM states: COLLECT, STALL.
- COLLECT, bit_vld=1:
  - Bit shifts into sr at the position set by MSB_FIRST; cnt increments.
  - Word complete when cnt==LAST and bit_vld=1. LAST = WIDTH-1, or WIDTH when the parity bit is enabled.
  - On completion with slot free: word_out loads the completed word (including the current bit), word_vld=1 at the next edge, cnt=0, state stays COLLECT.
  - On completion with slot not free: completed word is held in sr, state goes to STALL, cnt=0.
- COLLECT, bit_vld=0: no change. Gaps of any length are legal.
- STALL:
  - Any bit_vld=1 is dropped and sets overflow=1.
  - When word_rdy=1: word_out loads sr, word_vld stays 1, state returns to COLLECT.
  - A bit arriving in the exit cycle is also dropped and sets overflow.
- word_vld clears on a handshake (word_vld && word_rdy) in a cycle with no new load.
  - If a load and a handshake occur in the same cycle, word_vld stays 1 and word_out takes the new word (back-to-back streaming, no bubble).
- Latency: word_vld rises on the edge that samples the last bit of the word; word_out is visible in the following cycle.
- word_out is stable while word_vld=1 and word_rdy=0.
- overflow is cleared only by rst.
- cnt wraps to 0 after each completed word. There is no other wrap-around.

Optional Feature:
- PARITY_CHECK_EN defined:
  - Each word is followed by one extra even-parity bit on bit_in; cnt runs 0..WIDTH.
  - The parity bit is not stored in word_out.
  - parity_err = XOR(data bits) XOR parity bit, registered with word_out and held with it.
  - In STALL, the held parity result transfers together with sr.
- PARITY_CHECK_EN undefined: words are WIDTH bits and parity_err is constant 0.

Decomposition:
- Package negedge_deser_pkg holds:
  - state enum (COLLECT=1'b0, STALL=1'b1);
  - counter width function clog2(WIDTH+1);
  - constant MAX_WIDTH=32.
- One natural sub-module: negedge_deser_slot, the output register. It handles load/handshake/hold and owns word_out, word_vld and parity_err.
- Shift register, counter and FSM stay in the top.

Test Plan:
- WIDTH=8, MSB_FIRST=1, word_rdy=1: bits 1,0,1,0,0,1,0,1 on 8 consecutive cycles -> word_out=8'hA5, word_vld pulses 1 cycle, overflow=0.
- Same stream with bit_vld gaps of 0..3 random cycles between bits -> word_out=8'hA5 exactly once.
- MSB_FIRST=0, same bit order -> word_out=8'hA5 bit-reversed = 8'hA5 (palindromic). Repeat with 1,1,0,0,0,0,0,0 -> word_out=8'h03.
- Back-pressure, word_rdy=0: send 8'hA5 then 8'h3C, then 3 more bits -> state STALL, overflow=1. Then raise word_rdy -> 8'hA5 consumed, next cycle word_out=8'h3C; dropped bits are never seen.
- Send 4 bits, assert rst for 1 cycle, then send 8'h0F -> all outputs 0 during reset; only 8'h0F emerges, word_vld=1 once.
- PARITY_CHECK_EN: 8'hA5 + parity 0 -> parity_err=0. 8'hA5 + parity 1 -> parity_err=1. 8'h07 + parity 1 -> parity_err=0.

Source files
------------

// File: rtl/negedge_deser_pkg.sv
// Shared types and sizing helpers for the negedge_deser serial-to-parallel collector.
package negedge_deser_pkg;

    localparam int unsigned MAX_WIDTH = 32;

    typedef enum logic {
        COLLECT = 1'b0,
        STALL   = 1'b1
    } state_t;

    // Counter must reach WIDTH when a trailing parity bit follows the data bits.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/negedge_deser_slot.sv
// Output register of negedge_deser: load / handshake / hold of word_out, word_vld and parity_err.
module negedge_deser_slot #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_word,
    input  logic             load_perr,
    input  logic             word_rdy,
    output logic [WIDTH-1:0] word_out,
    output logic             word_vld,
    output logic             parity_err
);

    // A load wins over a same-cycle handshake so streaming has no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_out   <= '0;
            word_vld   <= 1'b0;
            parity_err <= 1'b0;
        end else if (load) begin
            word_out   <= load_word;
            word_vld   <= 1'b1;
            parity_err <= load_perr;
        end else if (word_vld && word_rdy) begin
            word_vld   <= 1'b0;
            parity_err <= 1'b0;
        end
    end

endmodule

// File: rtl/negedge_deser.sv
// Posedge collector for a negedge-launched serial stream; WIDTH-bit words on valid/ready.
// Optional trailing even-parity bit per word when PARITY_CHECK_EN is defined.
module negedge_deser
    import negedge_deser_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_vld,
    output logic [WIDTH-1:0] word_out,
    output logic             word_vld,
    input  logic             word_rdy,
    output logic             overflow,
    output logic             parity_err
);

    localparam int unsigned CW = cnt_width(WIDTH);
`ifdef PARITY_CHECK_EN
    localparam int unsigned LAST = WIDTH;
`else
    localparam int unsigned LAST = WIDTH - 1;
`endif

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_q, sr_d, sr_shift, done_word, load_word;
    logic             ovf_q, ovf_d;
    logic             load, load_perr, done_perr, data_bit, slot_free;

    assign sr_shift  = MSB_FIRST ? {sr_q[WIDTH-2:0], bit_in} : {bit_in, sr_q[WIDTH-1:1]};
    assign slot_free = !word_vld || word_rdy;
    assign overflow  = ovf_q;

`ifdef PARITY_CHECK_EN
    logic par_q, par_d, held_q, held_d;
    // The parity bit never enters sr; it only closes the running XOR.
    assign data_bit  = (cnt_q < CW'(WIDTH));
    assign done_word = sr_q;
    assign done_perr = par_q ^ bit_in;
`else
    assign data_bit  = 1'b1;
    assign done_word = sr_shift;
    assign done_perr = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        ovf_d     = ovf_q;
        load      = 1'b0;
        load_word = sr_q;
        load_perr = 1'b0;
`ifdef PARITY_CHECK_EN
        par_d     = par_q;
        held_d    = held_q;
        load_perr = held_q;
`endif
        case (state_q)
            COLLECT: begin
                if (bit_vld) begin
                    if (cnt_q == CW'(LAST)) begin
                        cnt_d = '0;
`ifdef PARITY_CHECK_EN
                        par_d = 1'b0;
`endif
                        if (slot_free) begin
                            load      = 1'b1;
                            load_word = done_word;
                            load_perr = done_perr;
                        end else begin
                            sr_d    = done_word;
                            state_d = STALL;
`ifdef PARITY_CHECK_EN
                            held_d  = done_perr;
`endif
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                        if (data_bit) begin
                            sr_d = sr_shift;
`ifdef PARITY_CHECK_EN
                            par_d = par_q ^ bit_in;
`endif
                        end
                    end
                end
            end
            STALL: begin
                // Bits have nowhere to go while a completed word waits, including the exit cycle.
                if (bit_vld) begin
                    ovf_d = 1'b1;
                end
                if (word_rdy) begin
                    load    = 1'b1;
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            sr_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef PARITY_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            par_q  <= 1'b0;
            held_q <= 1'b0;
        end else begin
            par_q  <= par_d;
            held_q <= held_d;
        end
    end
`endif

    negedge_deser_slot #(
        .WIDTH(WIDTH)
    ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_word (load_word),
        .load_perr (load_perr),
        .word_rdy  (word_rdy),
        .word_out  (word_out),
        .word_vld  (word_vld),
        .parity_err(parity_err)
    );

endmodule

// File: tb/tb_negedge_deser.sv
// Directed bench for negedge_deser: MSB-first and LSB-first instances share one input stream.
module tb_negedge_deser;
    import negedge_deser_pkg::*;

    logic       clk = 1'b0;
    logic       rst, bit_in, bit_vld, word_rdy;
    logic [7:0] out_m, out_l;
    logic       vld_m, vld_l, ovf_m, ovf_l, perr_m, perr_l;
    int         checks = 0;
    int         errors = 0;
    int         hs = 0;
    int         hs0;

    always #5 clk = ~clk;

    negedge_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_vld(bit_vld),
        .word_out(out_m), .word_vld(vld_m), .word_rdy(word_rdy),
        .overflow(ovf_m), .parity_err(perr_m)
    );

    negedge_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_vld(bit_vld),
        .word_out(out_l), .word_vld(vld_l), .word_rdy(word_rdy),
        .overflow(ovf_l), .parity_err(perr_l)
    );

    // Count accepted words on the MSB-first instance.
    always @(posedge clk) begin
        if (!rst && vld_m && word_rdy) hs <= hs + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic b);
        bit_in  = b;
        bit_vld = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit_vld = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_data(input logic [7:0] w, input int max_gap);
        for (int i = 7; i >= 0; i--) begin
            drive(w[i]);
            if (i != 0 && max_gap > 0) idle(int'($urandom_range(0, max_gap)));
        end
    endtask

    task automatic send_word(input logic [7:0] w, input int max_gap);
        send_data(w, max_gap);
`ifdef PARITY_CHECK_EN
        drive(^w);
`endif
    endtask

    initial begin
        rst      = 1'b1;
        bit_in   = 1'b0;
        bit_vld  = 1'b0;
        word_rdy = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_out", 32'(out_m), 32'h0);
        check("reset_vld", 32'(vld_m), 32'h0);
        check("reset_ovf", 32'(ovf_m), 32'h0);
        check("reset_perr", 32'(perr_m), 32'h0);
        check("reset_state", 32'(dut_m.state_q), 32'(COLLECT));
        rst = 1'b0;
        @(negedge clk);

        // Plain word, consumer always ready
        hs0 = hs;
        send_word(8'hA5, 0);
        check("a5_vld", 32'(vld_m), 32'h1);
        check("a5_out_m", 32'(out_m), 32'hA5);
        check("a5_out_l", 32'(out_l), 32'hA5);
        check("a5_ovf", 32'(ovf_m), 32'h0);
        check("a5_perr", 32'(perr_m), 32'h0);
        idle(1);
        check("a5_pulse", 32'(vld_m), 32'h0);
        check("a5_once", 32'(hs - hs0), 32'h1);

        // Same word with random gaps between bits
        hs0 = hs;
        send_word(8'hA5, 3);
        check("gap_vld", 32'(vld_m), 32'h1);
        check("gap_out", 32'(out_m), 32'hA5);
        idle(1);
        check("gap_once", 32'(hs - hs0), 32'h1);

        // Bit order: MSB-first yields C0, LSB-first yields 03
        send_word(8'hC0, 0);
        check("ord_out_m", 32'(out_m), 32'hC0);
        check("ord_out_l", 32'(out_l), 32'h03);
        idle(1);

        // Back-pressure: second word stalls, extra bits are dropped
        hs0 = hs;
        word_rdy = 1'b0;
        send_word(8'hA5, 0);
        check("bp_first_vld", 32'(vld_m), 32'h1);
        send_word(8'h3C, 0);
        check("bp_ovf_before", 32'(ovf_m), 32'h0);
        drive(1'b1);
        drive(1'b1);
        drive(1'b1);
        idle(1);
        check("bp_state", 32'(dut_m.state_q), 32'(STALL));
        check("bp_ovf", 32'(ovf_m), 32'h1);
        check("bp_ovf_l", 32'(ovf_l), 32'h1);
        check("bp_hold_out", 32'(out_m), 32'hA5);
        check("bp_hold_vld", 32'(vld_m), 32'h1);
        word_rdy = 1'b1;
        @(negedge clk);
        check("bp_next_out", 32'(out_m), 32'h3C);
        check("bp_next_out_l", 32'(out_l), 32'h3C);
        check("bp_next_vld", 32'(vld_m), 32'h1);
        check("bp_exit_state", 32'(dut_m.state_q), 32'(COLLECT));
        @(negedge clk);
        check("bp_drain_vld", 32'(vld_m), 32'h0);
        check("bp_two_words", 32'(hs - hs0), 32'h2);
        check("bp_ovf_sticky", 32'(ovf_m), 32'h1);

        // Reset mid-word discards the partial word and clears overflow
        drive(1'b1);
        drive(1'b0);
        drive(1'b1);
        drive(1'b0);
        rst     = 1'b1;
        bit_vld = 1'b0;
        @(negedge clk);
        check("rst_out", 32'(out_m), 32'h0);
        check("rst_vld", 32'(vld_m), 32'h0);
        check("rst_ovf", 32'(ovf_m), 32'h0);
        check("rst_perr", 32'(perr_m), 32'h0);
        rst = 1'b0;
        hs0 = hs;
        send_word(8'h0F, 0);
        check("post_rst_out_m", 32'(out_m), 32'h0F);
        check("post_rst_out_l", 32'(out_l), 32'hF0);
        check("post_rst_vld", 32'(vld_m), 32'h1);
        idle(1);
        check("post_rst_pulse", 32'(vld_m), 32'h0);
        check("post_rst_once", 32'(hs - hs0), 32'h1);

`ifdef PARITY_CHECK_EN
        // Even parity: error flag is XOR of data bits and the parity bit
        send_data(8'hA5, 0);
        drive(1'b0);
        check("par_a5_0_out", 32'(out_m), 32'hA5);
        check("par_a5_0", 32'(perr_m), 32'h0);
        idle(1);
        send_data(8'hA5, 0);
        drive(1'b1);
        check("par_a5_1", 32'(perr_m), 32'h1);
        check("par_a5_1_vld", 32'(vld_m), 32'h1);
        idle(1);
        send_data(8'h07, 0);
        drive(1'b1);
        check("par_07_1", 32'(perr_m), 32'h0);
        check("par_07_out", 32'(out_m), 32'h07);
        idle(1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
